// File: rtl/draw_pkg.sv
// Shared types and constants for the screen-draw sequencer and its pixel-bus mux.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package draw_pkg;

  localparam int VGA_W = 160;
  localparam int VGA_H = 120;
  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int C_W   = 3;
  localparam int R_W   = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLR_RUN,
    CLR_REL,
    CIR_RUN,
    CIR_REL,
    DONE
  } sched_state_t;

  // One pixel write toward the VGA adapter.
  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] colour;
    logic           plot;
  } pix_t;

  // Circle parameters captured when a request is accepted.
  typedef struct packed {
    logic [X_W-1:0] cx;
    logic [Y_W-1:0] cy;
    logic [R_W-1:0] r;
    logic [C_W-1:0] colour;
  } circ_par_t;

endpackage

// File: rtl/draw_plot_mux.sv
// Two-way pixel-bus select; forces an all-zero bus when neither source is selected.
// Latency: combinational, zero cycles.
// Backpressure: none; the adapter always accepts a pixel, so plot is passed straight through.
//
// Ports:
//   sel_a / sel_b  in  source select (sel_a has priority; the scheduler never raises both)
//   pix_a / pix_b  in  pixel buses from the two engines
//   pix_o          out selected bus, or zero when idle
module plot_mux
  import draw_pkg::*;
(
  input  logic sel_a,
  input  logic sel_b,
  input  pix_t pix_a,
  input  pix_t pix_b,
  output pix_t pix_o
);

  always_comb begin
    pix_o = '0;
    if (sel_a) begin
      pix_o = pix_a;
    end else if (sel_b) begin
      pix_o = pix_b;
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// Sequences one screen draw: clear the frame with the fillscreen engine, then draw one circle.
// Latency: accept + clear time + 1 + circle time + 1 + 1 cycles until done.
// Backpressure: level start/done handshake; done is held until the requester drops start.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   start / done                   request level in, completion level out
//   centre_x/centre_y/radius/colour circle request, captured at accept
//   fill_start, fill_colour        fillscreen control (fill_colour is the constant clear colour)
//   fill_done, fill_x/y/pix_colour/plot  fillscreen status and pixel bus
//   circ_start, circ_cx/cy/r/colour      circle control with captured parameters
//   circ_done, circ_x/y/pix_colour/plot  circle status and pixel bus
//   vga_x/y/colour/plot            single plot port toward the VGA adapter
module draw_scheduler
  import draw_pkg::*;
#(
  parameter logic [C_W-1:0] CLEAR_COLOUR = 3'b000,
  parameter bit             CLEAR_EN     = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic           done,
  input  logic [X_W-1:0] centre_x,
  input  logic [Y_W-1:0] centre_y,
  input  logic [R_W-1:0] radius,
  input  logic [C_W-1:0] colour,
  output logic           fill_start,
  output logic [C_W-1:0] fill_colour,
  input  logic           fill_done,
  input  logic [X_W-1:0] fill_x,
  input  logic [Y_W-1:0] fill_y,
  input  logic [C_W-1:0] fill_pix_colour,
  input  logic           fill_plot,
  output logic           circ_start,
  output logic [X_W-1:0] circ_cx,
  output logic [Y_W-1:0] circ_cy,
  output logic [R_W-1:0] circ_r,
  output logic [C_W-1:0] circ_colour,
  input  logic           circ_done,
  input  logic [X_W-1:0] circ_x,
  input  logic [Y_W-1:0] circ_y,
  input  logic [C_W-1:0] circ_pix_colour,
  input  logic           circ_plot,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [C_W-1:0] vga_colour,
  output logic           vga_plot
);

  sched_state_t state_q, state_d;
  circ_par_t    par_q, par_d;

  pix_t fill_pix, circ_pix, vga_pix;

  always_comb begin
    state_d = state_q;
    par_d   = par_q;
    case (state_q)
      IDLE: begin
        // done is low in IDLE, but keep the full accept condition so a
        // lingering completion can never re-trigger a sequence.
        if (start && !done) begin
          par_d   = '{cx: centre_x, cy: centre_y, r: radius, colour: colour};
          state_d = CLEAR_EN ? CLR_RUN : CIR_RUN;
        end
      end
      CLR_RUN: if (fill_done) state_d = CLR_REL;
      // One cycle with fill_start low so the engine can drop its done.
      CLR_REL: state_d = CIR_RUN;
      CIR_RUN: if (circ_done) state_d = CIR_REL;
      CIR_REL: state_d = DONE;
      DONE:    if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      par_q   <= '0;
    end else begin
      state_q <= state_d;
      par_q   <= par_d;
    end
  end

  // Control outputs decode registered state only: no path from any input.
  assign fill_start  = (state_q == CLR_RUN);
  assign circ_start  = (state_q == CIR_RUN);
  assign done        = (state_q == DONE);
  assign fill_colour = CLEAR_COLOUR;

  assign circ_cx     = par_q.cx;
  assign circ_cy     = par_q.cy;
  assign circ_r      = par_q.r;
  assign circ_colour = par_q.colour;

  assign fill_pix = '{x: fill_x, y: fill_y, colour: fill_pix_colour, plot: fill_plot};
  assign circ_pix = '{x: circ_x, y: circ_y, colour: circ_pix_colour, plot: circ_plot};

  plot_mux u_plot_mux (
    .sel_a (fill_start),
    .sel_b (circ_start),
    .pix_a (fill_pix),
    .pix_b (circ_pix),
    .pix_o (vga_pix)
  );

  assign vga_x      = vga_pix.x;
  assign vga_y      = vga_pix.y;
  assign vga_colour = vga_pix.colour;
  assign vga_plot   = vga_pix.plot;

endmodule
